uart_cmd_parser: RTL

Sits between the UART byte receiver and the ALU inside uart_alu_top. Collects a fixed 4-byte command frame from rx byte strobes: operand A, operand B, opcode, control. It validates the frame and presents it to the ALU through a valid/ready handshake. An inter-byte timeout resynchronises after a partial frame; a one-byte skid register absorbs a byte that arrives while an issue is stalled.

---
 rtl/uart_cmd_parser_pkg.sv | 32 +++
 rtl/uart_cmd_parser_if.sv | 12 +
 rtl/uart_frame_timer.sv | 27 ++
 rtl/uart_cmd_parser.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser and the ALU
// it feeds: state encoding, opcodes, control-byte layout, frame legality.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_GOT_B  = 3'd2,
    S_GOT_OP = 3'd3,
    S_ISSUE  = 3'd4
  } state_t;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_SHL  = 8'h05;
  localparam logic [7:0] OP_SHR  = 8'h06;
  localparam logic [7:0] OP_MAX  = 8'h07;

  localparam int CTRL_ECHO_BIT = 0;
  localparam int BYTE_BITS     = 10;

  // Only bit0 of the control byte carries meaning; anything else marks a corrupt frame.
  function automatic logic frame_legal(input logic [7:0] op,
                                       input logic [7:0] ctrl,
                                       input logic [7:0] op_max);
    return (op <= op_max) && (ctrl[7:1] == 7'd0);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Command handshake between the frame parser (master) and the ALU (slave).
interface uart_cmd_parser_if;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] cmd_op;
  logic       cmd_echo;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_a, cmd_b, cmd_op, cmd_echo, cmd_valid, input cmd_ready);
  modport slave  (input cmd_a, cmd_b, cmd_op, cmd_echo, cmd_valid, output cmd_ready);
endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer; done is asserted in the last cycle before the
// gap reaches LIMIT cycles so the caller acts exactly LIMIT edges after clear.
module uart_frame_timer #(
  parameter int LIMIT = 208320
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && count != LAST)
      count <= count + 1'b1;
  end

  assign done = enable && (count == LAST);
endmodule

// File: rtl/uart_cmd_parser.sv
// Collects A/B/opcode/control frames from the UART receiver and hands
// legal commands to the ALU over a valid/ready handshake.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         BIT_CYCLES    = 5208,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] OP_LIMIT      = OP_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_err,
  uart_cmd_parser_if.master         cmd,
  output logic                      busy,
  output logic                      frame_err,
  output logic [7:0]                err_cnt
);
  localparam int LIMIT = BIT_CYCLES * BYTE_BITS * TIMEOUT_BYTES;

  state_t     state, state_next;
  logic [7:0] a_q, b_q, op_q, skid_q;
  logic       skid_full;
  logic [7:0] cmd_a_q, cmd_b_q, cmd_op_q;
  logic       cmd_echo_q, cmd_valid_q;

  logic byte_ok, in_frame, timeout, legal;
  logic load_a, load_a_skid, load_b, load_op, issue, transfer;
  logic skid_store, skid_clear, err_next;

  assign byte_ok  = rx_valid && !rx_err;
  assign in_frame = (state == S_GOT_A) || (state == S_GOT_B) || (state == S_GOT_OP);
  assign legal    = frame_legal(op_q, rx_data, OP_LIMIT);

  uart_frame_timer #(.LIMIT(LIMIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_frame || byte_ok),
    .enable (in_frame),
    .done   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (byte_ok) state_next = S_GOT_A;
      S_GOT_A:  if (rx_err) state_next = S_IDLE;
                else if (rx_valid) state_next = S_GOT_B;
                else if (timeout) state_next = S_IDLE;
      S_GOT_B:  if (rx_err) state_next = S_IDLE;
                else if (rx_valid) state_next = S_GOT_OP;
                else if (timeout) state_next = S_IDLE;
      S_GOT_OP: if (rx_err) state_next = S_IDLE;
                else if (rx_valid) state_next = legal ? S_ISSUE : S_IDLE;
                else if (timeout) state_next = S_IDLE;
      S_ISSUE:  if (cmd_ready_w()) state_next = (skid_full || byte_ok) ? S_GOT_A : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  function automatic logic cmd_ready_w();
    return cmd.cmd_ready;
  endfunction

  // A byte that lands on the transfer cycle with an empty skid becomes the next operand A.
  always_comb begin
    load_a      = 1'b0;
    load_a_skid = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    issue       = 1'b0;
    transfer    = 1'b0;
    skid_store  = 1'b0;
    skid_clear  = 1'b0;
    err_next    = 1'b0;
    case (state)
      S_IDLE: begin
        err_next = rx_err;
        load_a   = byte_ok;
      end
      S_GOT_A: begin
        err_next = rx_err || (!rx_valid && timeout);
        load_b   = byte_ok;
      end
      S_GOT_B: begin
        err_next = rx_err || (!rx_valid && timeout);
        load_op  = byte_ok;
      end
      S_GOT_OP: begin
        err_next = rx_err || (!rx_valid && timeout) || (byte_ok && !legal);
        issue    = byte_ok && legal;
      end
      S_ISSUE: begin
        err_next = rx_err || (byte_ok && skid_full);
        transfer = cmd.cmd_ready;
        if (cmd.cmd_ready) begin
          if (skid_full) begin
            load_a_skid = 1'b1;
            skid_clear  = 1'b1;
          end else begin
            load_a = byte_ok;
          end
        end else begin
          skid_store = byte_ok && !skid_full;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      skid_q      <= '0;
      skid_full   <= 1'b0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      cmd_op_q    <= '0;
      cmd_echo_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (load_a)           a_q <= rx_data;
      else if (load_a_skid) a_q <= skid_q;
      if (load_b)  b_q  <= rx_data;
      if (load_op) op_q <= rx_data;
      if (skid_store) begin
        skid_q    <= rx_data;
        skid_full <= 1'b1;
      end else if (skid_clear) begin
        skid_full <= 1'b0;
      end
      if (issue) begin
        cmd_a_q     <= a_q;
        cmd_b_q     <= b_q;
        cmd_op_q    <= op_q;
        cmd_echo_q  <= rx_data[CTRL_ECHO_BIT];
        cmd_valid_q <= 1'b1;
      end else if (transfer) begin
        cmd_valid_q <= 1'b0;
      end
      frame_err <= err_next;
      if (err_next && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign cmd.cmd_a     = cmd_a_q;
  assign cmd.cmd_b     = cmd_b_q;
  assign cmd.cmd_op    = cmd_op_q;
  assign cmd.cmd_echo  = cmd_echo_q;
  assign cmd.cmd_valid = cmd_valid_q;
  assign busy          = (state != S_IDLE);
endmodule
